// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU with valid/ready fetch, read and write.
// Define HACK_CPU_HALT_EN to add a HALT state entered on a taken self-jump.
module hack_cpu_mc #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instruction,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  inM,
  input  logic              inM_valid,
  input  logic              writeM_ready,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic              readM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH, READ, EXEC, WRITE, HALT
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ir, mr, a_reg, d_reg;
  logic [WIDTH-1:0] x0, x1, y0, y1, y2, f, res;
  logic [WIDTH-1:0] a_new, out_nx;
  logic [ADDR_W-1:0] target, pc_nx;
  logic is_c, dest_a, dest_d, dest_m;
  logic zr, ng, jump, commit;
  logic read_nx, write_nx;

  assign is_c   = ir[WIDTH-1];
  assign dest_a = is_c & ir[5];
  assign dest_d = is_c & ir[4];
  assign dest_m = is_c & ir[3];

  always_comb begin
    x0  = ir[11] ? '0 : d_reg;
    x1  = ir[10] ? ~x0 : x0;
    y0  = ir[12] ? mr : a_reg;
    y1  = ir[9] ? '0 : y0;
    y2  = ir[8] ? ~y1 : y1;
    f   = ir[7] ? x1 + y2 : x1 & y2;
    res = ir[6] ? ~f : f;
  end

  assign zr     = (res == '0);
  assign ng     = res[WIDTH-1];
  assign jump   = is_c & ((ir[2] & ng) | (ir[1] & zr)
                | (ir[0] & ~ng & ~zr));
  // Jump target and addressM both see A before this commit
  assign target = a_reg[ADDR_W-1:0];
  assign pc_nx  = jump ? target : pc + 1'b1;
  assign a_new  = is_c ? res : {1'b0, ir[WIDTH-2:0]};
  assign commit = (state == EXEC && !dest_m)
                | (state == WRITE && writeM_ready);

  assign addressM = a_reg[ADDR_W-1:0];

`ifdef HACK_CPU_HALT_EN
  logic self_jump;
  assign self_jump = jump & (target == pc);
  assign halted    = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
      ir     <= '0;
      mr     <= '0;
      outM   <= '0;
      writeM <= 1'b0;
      readM  <= 1'b0;
    end else begin
      state  <= state_nx;
      readM  <= read_nx;
      writeM <= write_nx;
      outM   <= out_nx;
      if (state == FETCH && instr_valid) ir <= instruction;
      if (state == READ && inM_valid) mr <= inM;
      if (commit) begin
        pc <= pc_nx;
        if (!is_c || dest_a) a_reg <= a_new;
        if (dest_d) d_reg <= res;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:
        if (instr_valid)
          state_nx = (instruction[WIDTH-1] && instruction[12])
                   ? READ : EXEC;
      READ:  if (inM_valid) state_nx = EXEC;
      EXEC:  state_nx = dest_m ? WRITE : FETCH;
      WRITE: if (writeM_ready) state_nx = FETCH;
      HALT:  state_nx = HALT;
      default: state_nx = FETCH;
    endcase
`ifdef HACK_CPU_HALT_EN
    if (commit && self_jump) state_nx = HALT;
`endif
  end

  always_comb begin
    read_nx  = (state_nx == READ);
    write_nx = (state_nx == WRITE);
    out_nx   = (state == EXEC && dest_m) ? res : outM;
  end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb_hack_cpu_mc: directed vectors, corner sequences and a random program
// checked against an instruction-level model of the Hack ISA.
`timescale 1ns/1ps
module tb_hack_cpu_mc;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, instr_valid, inM_valid, writeM_ready;
  logic [15:0] instruction, inM, outM;
  logic        writeM, readM, halted;
  logic [14:0] addressM, pc;

  logic        w_reset, w_instr_valid, w_inM_valid, w_writeM_ready;
  logic [23:0] w_instruction, w_inM, w_outM;
  logic        w_writeM, w_readM, w_halted;
  logic [19:0] w_addressM, w_pc;

  hack_cpu_mc dut (
    .clock(clock), .reset(reset),
    .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM), .inM_valid(inM_valid), .writeM_ready(writeM_ready),
    .outM(outM), .writeM(writeM), .readM(readM),
    .addressM(addressM), .pc(pc), .halted(halted)
  );

  hack_cpu_mc #(.WIDTH(24), .ADDR_W(20)) dutw (
    .clock(clock), .reset(w_reset),
    .instruction(w_instruction), .instr_valid(w_instr_valid),
    .inM(w_inM), .inM_valid(w_inM_valid),
    .writeM_ready(w_writeM_ready),
    .outM(w_outM), .writeM(w_writeM), .readM(w_readM),
    .addressM(w_addressM), .pc(w_pc), .halted(w_halted)
  );

  localparam logic [5:0] C_ZERO = 6'b101010, C_ONE = 6'b111111;
  localparam logic [5:0] C_M1 = 6'b111010, C_D = 6'b001100;
  localparam logic [5:0] C_A = 6'b110000, C_ND = 6'b001101;
  localparam logic [5:0] C_NEGD = 6'b001111, C_DP1 = 6'b011111;
  localparam logic [5:0] C_AP1 = 6'b110111, C_DM1 = 6'b001110;
  localparam logic [5:0] C_AM1 = 6'b110010, C_DPA = 6'b000010;
  localparam logic [5:0] C_DMA = 6'b010011, C_AMD = 6'b000111;
  localparam logic [5:0] C_DAND = 6'b000000, C_DOR = 6'b010101;

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                     input logic [2:0] d,
                                     input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  function automatic logic [23:0] ci24(input logic [5:0] c,
                                       input logic [2:0] d,
                                       input logic [2:0] j);
    return {1'b1, 10'h3FF, 1'b0, c, d, j};
  endfunction

  logic [14:0] epc;
  int          rc, wc;
  logic        wr_seen;
  logic [15:0] w_data;
  logic [14:0] w_addr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One instruction with handshakes answered after md/wd wait cycles.
  task automatic run(input logic [15:0] ins, input logic [15:0] mval,
                     input int md, input int wd, input int jt);
    int n;
    n = 2 + ((ins[15] && ins[12]) ? md + 1 : 0)
          + ((ins[15] && ins[3]) ? wd + 1 : 0);
    rc = 0;
    wc = 0;
    wr_seen = 1'b0;
    instruction = ins;
    instr_valid = 1'b1;
    inM = mval;
    for (int i = 0; i < n; i++) begin
      tick();
      instr_valid = 1'b0;
      if (readM) rc++;
      inM_valid = readM && (rc > md);
      if (writeM) begin
        wc++;
        wr_seen = 1'b1;
        w_data = outM;
        w_addr = addressM;
      end
      writeM_ready = writeM && (wc > wd);
    end
    inM_valid = 1'b0;
    writeM_ready = 1'b0;
    epc = (jt < 0) ? epc + 15'd1 : jt[14:0];
    check("pc", 32'(pc), 32'(epc));
  endtask

  task automatic set_a(input logic [14:0] v);
    run({1'b0, v}, 16'h0, 0, 0, -1);
  endtask

  task automatic set_d(input logic [14:0] v);
    set_a(v);
    run(ci(1'b0, C_A, 3'b010, 3'b000), 16'h0, 0, 0, -1);
  endtask

  task automatic run24(input logic [23:0] ins, input int n);
    w_instruction = ins;
    w_instr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      w_instr_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [14:0] d;
    logic [14:0] a;
    logic        m;
    logic [15:0] mv;
    logic [5:0]  c;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[17];

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  logic [15:0] dmem_m [0:32767];
  logic [15:0] q_wd[$], o_wd[$];
  logic [14:0] q_wa[$], o_wa[$];
  logic [14:0] q_pc[$], o_pc[$];

  // Instruction-level interpreter: no cycles, just architectural effects.
  task automatic model(input int steps);
    logic [15:0] ra, rd, ins;
    logic [14:0] mp, nxt;
    int unsigned x, y, r;
    int sr;
    bit tk;
    ra = 16'h0;
    rd = 16'h0;
    mp = 15'h0;
    for (int s = 0; s < steps; s++) begin
      ins = imem[mp];
      if (!ins[15]) begin
        ra = {1'b0, ins[14:0]};
        mp = mp + 15'd1;
        q_pc.push_back(mp);
      end else begin
        x = ins[11] ? 32'd0 : {16'd0, rd};
        if (ins[10]) x = ~x & 32'hFFFF;
        y = ins[12] ? {16'd0, dmem_m[ra[14:0]]} : {16'd0, ra};
        if (ins[9]) y = 32'd0;
        if (ins[8]) y = ~y & 32'hFFFF;
        r = (ins[7] ? x + y : x & y) & 32'hFFFF;
        if (ins[6]) r = ~r & 32'hFFFF;
        sr = (r >= 32'h8000) ? int'(r) - 65536 : int'(r);
        tk = (ins[2] && sr < 0) || (ins[1] && sr == 0)
          || (ins[0] && sr > 0);
        nxt = tk ? ra[14:0] : mp + 15'd1;
        if (ins[3]) begin
          dmem_m[ra[14:0]] = r[15:0];
          q_wa.push_back(ra[14:0]);
          q_wd.push_back(r[15:0]);
        end
        if (ins[4]) rd = r[15:0];
        if (ins[5]) ra = r[15:0];
`ifdef HACK_CPU_HALT_EN
        if (tk && nxt == mp) break;
`endif
        if (nxt != mp) q_pc.push_back(nxt);
        mp = nxt;
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [14:0] lastpc;
    int lim;
    reset = 1'b1;
    instruction = 16'h0;
    instr_valid = 1'b0;
    inM = 16'h0;
    inM_valid = 1'b0;
    writeM_ready = 1'b0;
    w_reset = 1'b1;
    w_instruction = 24'h0;
    w_instr_valid = 1'b0;
    w_inM = 24'h0;
    w_inM_valid = 1'b1;
    w_writeM_ready = 1'b1;
    epc = 15'h0;

    vt[0]  = '{15'd5, 15'd3, 1'b0, 16'h0, C_DPA, 16'h0008};
    vt[1]  = '{15'd5, 15'd3, 1'b0, 16'h0, C_DMA, 16'h0002};
    vt[2]  = '{15'd3, 15'd5, 1'b0, 16'h0, C_DMA, 16'hFFFE};
    vt[3]  = '{15'd5, 15'd3, 1'b0, 16'h0, C_AMD, 16'hFFFE};
    vt[4]  = '{15'h00F0, 15'h0FF0, 1'b0, 16'h0, C_DAND, 16'h00F0};
    vt[5]  = '{15'h00F0, 15'h0F0F, 1'b0, 16'h0, C_DOR, 16'h0FFF};
    vt[6]  = '{15'h1234, 15'd0, 1'b0, 16'h0, C_ND, 16'hEDCB};
    vt[7]  = '{15'd1, 15'd0, 1'b0, 16'h0, C_NEGD, 16'hFFFF};
    vt[8]  = '{15'h7FFF, 15'd0, 1'b0, 16'h0, C_DP1, 16'h8000};
    vt[9]  = '{15'd0, 15'd0, 1'b0, 16'h0, C_DM1, 16'hFFFF};
    vt[10] = '{15'd0, 15'd0, 1'b0, 16'h0, C_ZERO, 16'h0000};
    vt[11] = '{15'd0, 15'd0, 1'b0, 16'h0, C_ONE, 16'h0001};
    vt[12] = '{15'd0, 15'd0, 1'b0, 16'h0, C_M1, 16'hFFFF};
    vt[13] = '{15'd10, 15'd20, 1'b1, 16'hFFFF, C_DPA, 16'h0009};
    vt[14] = '{15'd2, 15'd20, 1'b1, 16'h0007, C_AMD, 16'h0005};
    vt[15] = '{15'd0, 15'h7FFF, 1'b0, 16'h0, C_AP1, 16'h8000};
    vt[16] = '{15'h0F0F, 15'h00FF, 1'b0, 16'h0, C_DMA, 16'h0E10};

    tick();
    reset = 1'b0;
    w_reset = 1'b0;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_addr", 32'(addressM), 32'h0);
    check("rst_outM", 32'(outM), 32'h0);
    check("rst_req", {30'h0, writeM, readM}, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    instruction = 16'h1234;
    instr_valid = 1'b1;
    tick();
    check("ainst_pc1", 32'(pc), 32'h0);
    tick();
    instr_valid = 1'b0;
    check("ainst_pc2", 32'(pc), 32'h1);
    check("ainst_A", 32'(addressM), 32'h1234);
    check("ainst_wm", 32'(writeM), 32'h0);
    epc = 15'd1;

    set_a(15'd5);
    run(16'hFDD8, 16'd7, 3, 2, -1);
    check("mrmw_rcnt", 32'(rc), 32'd4);
    check("mrmw_wcnt", 32'(wc), 32'd3);
    check("mrmw_out", 32'(w_data), 32'd8);
    check("mrmw_addr", 32'(w_addr), 32'd5);
    check("mrmw_wm_low", 32'(writeM), 32'h0);
    run(ci(1'b0, C_D, 3'b001, 3'b000), 16'h0, 0, 0, -1);
    check("mrmw_D", 32'(w_data), 32'd8);

    set_a(15'd9);
    run(ci(1'b1, C_AM1, 3'b101, 3'b000), 16'd3, 0, 0, -1);
    check("amm1_addr", 32'(w_addr), 32'd9);
    check("amm1_out", 32'(w_data), 32'd2);
    check("amm1_A", 32'(addressM), 32'd2);

    set_d(15'd1);
    set_a(15'd40);
    run(ci(1'b0, C_D, 3'b000, 3'b001), 16'h0, 0, 0, 40);
    set_d(15'd0);
    set_a(15'd40);
    run(ci(1'b0, C_D, 3'b000, 3'b001), 16'h0, 0, 0, -1);
    run(ci(1'b0, C_D, 3'b000, 3'b010), 16'h0, 0, 0, 40);
    set_d(15'h7FFF);
    run(ci(1'b0, C_DP1, 3'b010, 3'b000), 16'h0, 0, 0, -1);
    set_a(15'd40);
    run(ci(1'b0, C_D, 3'b000, 3'b001), 16'h0, 0, 0, -1);
    run(ci(1'b0, C_D, 3'b000, 3'b100), 16'h0, 0, 0, 40);

    set_a(15'h7FFF);
    run(ci(1'b0, C_ZERO, 3'b000, 3'b111), 16'h0, 0, 0, 32'h7FFF);
    set_a(15'd0);

    for (int i = 0; i < 17; i++) begin
      set_d(vt[i].d);
      set_a(vt[i].a);
      run(ci(vt[i].m, vt[i].c, 3'b001, 3'b000), vt[i].mv, 0, 0, -1);
      check($sformatf("vec%0d_wr", i), 32'(wr_seen), 32'h1);
      check($sformatf("vec%0d_out", i), 32'(w_data), 32'(vt[i].exp));
      check($sformatf("vec%0d_addr", i), 32'(w_addr), 32'(vt[i].a));
    end

    set_a(15'd7);
    instruction = ci(1'b0, C_D, 3'b001, 3'b000);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("rstw_wm_on", 32'(writeM), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_wm_off", 32'(writeM), 32'h0);
    check("rstw_pc", 32'(pc), 32'h0);
    tick();
    check("rstw_abandon", {30'h0, writeM, readM}, 32'h0);
    epc = 15'h0;

    set_a(15'd7);
    instruction = ci(1'b1, C_A, 3'b010, 3'b000);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("rstr_rm_on", 32'(readM), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstr_rm_off", 32'(readM), 32'h0);
    check("rstr_addr", 32'(addressM), 32'h0);
    epc = 15'h0;

    set_a(15'd3);
    run(ci(1'b0, C_A, 3'b010, 3'b000), 16'h0, 0, 0, -1);
    set_a(15'd3);
    run(ci(1'b0, C_ZERO, 3'b000, 3'b111), 16'h0, 0, 0, 3);
`ifdef HACK_CPU_HALT_EN
    check("halt_on", 32'(halted), 32'h1);
    instruction = 16'h0005;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    instr_valid = 1'b0;
    check("halt_pc", 32'(pc), 32'd3);
    check("halt_A", 32'(addressM), 32'd3);
    check("halt_req", {30'h0, writeM, readM}, 32'h0);
    check("halt_hold", 32'(halted), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_rst_pc", 32'(pc), 32'h0);
    check("halt_rst", 32'(halted), 32'h0);
`else
    check("selfjmp_nohalt", 32'(halted), 32'h0);
    run(16'h0005, 16'h0, 0, 0, -1);
    check("selfjmp_A", 32'(addressM), 32'd5);
`endif

    check("w_rst_pc", 32'(w_pc), 32'h0);
    run24(24'h0FFFFF, 2);
    check("w_A", 32'(w_addressM), 32'hFFFFF);
    run24(ci24(C_ZERO, 3'b000, 3'b111), 2);
    check("w_jmp", 32'(w_pc), 32'hFFFFF);
    run24(24'h000001, 2);
    check("w_wrap", 32'(w_pc), 32'h0);
    run24(24'h7FFFFF, 2);
    run24(ci24(C_A, 3'b010, 3'b000), 2);
    run24(ci24(C_DP1, 3'b011, 3'b000), 3);
    check("w_outM", 32'(w_outM), 32'h800000);
    check("w_wm_low", {30'h0, w_writeM, w_readM}, 32'h0);
    run24(24'h000123, 2);
    run24(ci24(C_D, 3'b000, 3'b100), 2);
    check("w_jlt_ng", 32'(w_pc), 32'h123);
    run24(24'h000456, 2);
    run24(ci24(C_D, 3'b000, 3'b001), 2);
    check("w_jgt_ng", 32'(w_pc), 32'h125);
    check("w_halted", 32'(w_halted), 32'h0);

    for (int i = 0; i < 32768; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = {1'b0, 15'($urandom)};
        if ($urandom_range(0, 1) == 0) v[14:8] = 7'h0;
      end else begin
        v = {1'b1, 15'($urandom)};
        if ($urandom_range(0, 3) != 0) v[2:0] = 3'b000;
      end
      imem[i] = v;
      dmem[i] = 16'($urandom);
      dmem_m[i] = dmem[i];
    end
    model(3100);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    lastpc = 15'h0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      instruction = imem[pc];
      instr_valid = ($urandom_range(0, 2) != 0);
      inM = dmem[addressM];
      inM_valid = ($urandom_range(0, 2) != 0);
      writeM_ready = ($urandom_range(0, 2) != 0);
      if (writeM && writeM_ready) begin
        o_wa.push_back(addressM);
        o_wd.push_back(outM);
        dmem[addressM] = outM;
      end
      tick();
      if (pc != lastpc) begin
        o_pc.push_back(pc);
        lastpc = pc;
      end
    end
    instr_valid = 1'b0;
    inM_valid = 1'b0;
    writeM_ready = 1'b0;

    lim = (q_pc.size() < 100) ? q_pc.size() : 100;
    check("rand_progress", 32'(o_pc.size() >= lim), 32'h1);
    for (int i = 0; i < o_pc.size(); i++) begin
      if (i >= q_pc.size()) begin
        check("rand_pc_extra", 32'(o_pc.size()), 32'(q_pc.size()));
        break;
      end
      check($sformatf("rand_pc%0d", i), 32'(o_pc[i]), 32'(q_pc[i]));
      if (o_pc[i] !== q_pc[i]) break;
    end
    for (int i = 0; i < o_wa.size(); i++) begin
      if (i >= q_wa.size()) begin
        check("rand_wr_extra", 32'(o_wa.size()), 32'(q_wa.size()));
        break;
      end
      check($sformatf("rand_wa%0d", i), 32'(o_wa[i]), 32'(q_wa[i]));
      check($sformatf("rand_wd%0d", i), 32'(o_wd[i]), 32'(q_wd[i]));
      if (o_wa[i] !== q_wa[i] || o_wd[i] !== q_wd[i]) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
